// File: rtl/up_gpio_core_pkg.sv
// Shared definitions for the uP-bus GPIO core: register offsets and field positions.
// Optional input synchronizer in the core is enabled with `define UP_GPIO_INPUT_SYNC_EN.
package up_gpio_core_pkg;

  localparam int unsigned REG_OFFSET_W = 12;

  localparam logic [REG_OFFSET_W-1:0] REG_GPIO_DATA  = 12'h000;
  localparam logic [REG_OFFSET_W-1:0] REG_GPIO_TRI   = 12'h004;
  localparam logic [REG_OFFSET_W-1:0] REG_GPIO2_DATA = 12'h008;
  localparam logic [REG_OFFSET_W-1:0] REG_GPIO2_TRI  = 12'h00C;
  localparam logic [REG_OFFSET_W-1:0] REG_GIER       = 12'h11C;
  localparam logic [REG_OFFSET_W-1:0] REG_IP_ISR     = 12'h120;
  localparam logic [REG_OFFSET_W-1:0] REG_IP_IER     = 12'h128;

  localparam int unsigned GIER_EN_BIT = 31;

  // Word-aligned register offset: low 12 address bits with the sub-word bits cleared.
  function automatic logic [REG_OFFSET_W-1:0] reg_offset(
    input logic [REG_OFFSET_W-1:0] addr,
    input int unsigned             bus_bytes
  );
    return addr & ~REG_OFFSET_W'(bus_bytes - 1);
  endfunction

endpackage

// File: rtl/up_gpio_irq.sv
// Change detector plus GIER/IER/ISR registers and the registered level interrupt.
module up_gpio_irq #(
  parameter int unsigned GPIO_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  input  logic [GPIO_WIDTH-1:0] gpio_t,
  input  logic                  gier_we,
  input  logic                  ier_we,
  input  logic                  isr_we,
  input  logic                  wbit_gier,
  input  logic                  wbit_lsb,
  output logic                  gier,
  output logic                  ier,
  output logic                  isr,
  output logic                  irq
);

  logic [GPIO_WIDTH-1:0] gpio_prev;
  logic                  change_c;

  // Only pins configured as inputs can raise a change event.
  assign change_c = |((gpio_in ^ gpio_prev) & gpio_t);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gpio_prev <= '0;
      gier      <= 1'b0;
      ier       <= 1'b0;
      isr       <= 1'b0;
      irq       <= 1'b0;
    end else begin
      gpio_prev <= gpio_in;
      if (gier_we) gier <= wbit_gier;
      if (ier_we)  ier  <= wbit_lsb;
      // A new event in the same cycle as a write-1-to-clear keeps the status set.
      if (change_c)                  isr <= 1'b1;
      else if (isr_we && wbit_lsb)   isr <= 1'b0;
      irq <= gier & ier & isr;
    end
  end

endmodule

// File: rtl/up_gpio_core.sv
// Single-channel GPIO on the uP req/ack register bus, AXI GPIO register layout.
// Define UP_GPIO_INPUT_SYNC_EN to add a 2-flop synchronizer ahead of the input sample register.
module up_gpio_core
  import up_gpio_core_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned BUS_WIDTH     = 4,
  parameter int unsigned GPIO_WIDTH    = 32,
  parameter int unsigned IRQ_ENABLE    = 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     up_rreq,
  output logic                     up_rack,
  input  logic [ADDRESS_WIDTH-1:0] up_raddr,
  output logic [BUS_WIDTH*8-1:0]   up_rdata,
  input  logic                     up_wreq,
  output logic                     up_wack,
  input  logic [ADDRESS_WIDTH-1:0] up_waddr,
  input  logic [BUS_WIDTH*8-1:0]   up_wdata,
  output logic                     irq,
  input  logic [GPIO_WIDTH-1:0]    gpio_io_i,
  output logic [GPIO_WIDTH-1:0]    gpio_io_o,
  output logic [GPIO_WIDTH-1:0]    gpio_io_t
);

  localparam int unsigned DATA_W = BUS_WIDTH * 8;

  logic [GPIO_WIDTH-1:0]   gpio_raw;
  logic [GPIO_WIDTH-1:0]   gpio_in;
  logic [REG_OFFSET_W-1:0] roff;
  logic [REG_OFFSET_W-1:0] woff;
  logic                    data_we;
  logic                    tri_we;
  logic                    gier_we;
  logic                    ier_we;
  logic                    isr_we;
  logic                    gier;
  logic                    ier;
  logic                    isr;
  logic [DATA_W-1:0]       rdata_c;

`ifdef UP_GPIO_INPUT_SYNC_EN
  logic [GPIO_WIDTH-1:0] sync_q1;
  logic [GPIO_WIDTH-1:0] sync_q2;

  // Metastability guard for asynchronous pad inputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= gpio_io_i;
      sync_q2 <= sync_q1;
    end
  end

  assign gpio_raw = sync_q2;
`else
  assign gpio_raw = gpio_io_i;
`endif

  assign roff = reg_offset(up_raddr[REG_OFFSET_W-1:0], BUS_WIDTH);
  assign woff = reg_offset(up_waddr[REG_OFFSET_W-1:0], BUS_WIDTH);

  assign data_we = up_wreq && (woff == REG_GPIO_DATA);
  assign tri_we  = up_wreq && (woff == REG_GPIO_TRI);
  assign gier_we = up_wreq && (woff == REG_GIER);
  assign ier_we  = up_wreq && (woff == REG_IP_IER);
  assign isr_we  = up_wreq && (woff == REG_IP_ISR);

  // Upper address bits only alias the register window.
  if (ADDRESS_WIDTH > REG_OFFSET_W) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^{up_raddr[ADDRESS_WIDTH-1:REG_OFFSET_W],
                              up_waddr[ADDRESS_WIDTH-1:REG_OFFSET_W]};
  end

  // Read mux: driven pins read back their output value, input pins their sampled level.
  always_comb begin
    rdata_c = '0;
    case (roff)
      REG_GPIO_DATA:  rdata_c = DATA_W'((gpio_in & gpio_io_t) | (gpio_io_o & ~gpio_io_t));
      REG_GPIO_TRI:   rdata_c = DATA_W'(gpio_io_t);
      REG_GPIO2_DATA: rdata_c = '0;
      REG_GPIO2_TRI:  rdata_c = '0;
      REG_GIER:       rdata_c[GIER_EN_BIT] = gier;
      REG_IP_ISR:     rdata_c[0] = isr;
      REG_IP_IER:     rdata_c[0] = ier;
      default:        rdata_c = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      up_rack   <= 1'b0;
      up_wack   <= 1'b0;
      up_rdata  <= '0;
      gpio_io_o <= '0;
      gpio_io_t <= '1;
      gpio_in   <= '0;
    end else begin
      up_rack  <= up_rreq;
      up_wack  <= up_wreq;
      up_rdata <= up_rreq ? rdata_c : '0;
      gpio_in  <= gpio_raw;
      if (data_we) gpio_io_o <= up_wdata[GPIO_WIDTH-1:0];
      if (tri_we)  gpio_io_t <= up_wdata[GPIO_WIDTH-1:0];
    end
  end

  if (IRQ_ENABLE != 0) begin : g_irq
    up_gpio_irq #(
      .GPIO_WIDTH (GPIO_WIDTH)
    ) u_irq (
      .clk       (clk),
      .rstn      (rstn),
      .gpio_in   (gpio_in),
      .gpio_t    (gpio_io_t),
      .gier_we   (gier_we),
      .ier_we    (ier_we),
      .isr_we    (isr_we),
      .wbit_gier (up_wdata[GIER_EN_BIT]),
      .wbit_lsb  (up_wdata[0]),
      .gier      (gier),
      .ier       (ier),
      .isr       (isr),
      .irq       (irq)
    );
  end else begin : g_no_irq
    logic unused_irq_we;
    assign unused_irq_we = ^{gier_we, ier_we, isr_we};
    assign gier = 1'b0;
    assign ier  = 1'b0;
    assign isr  = 1'b0;
    assign irq  = 1'b0;
  end

endmodule

// File: tb/tb_up_gpio_core.sv
// Randomized scoreboard bench for up_gpio_core against a register-level reference model.
module tb_up_gpio_core;

`ifdef UP_GPIO_INPUT_SYNC_EN
  localparam int IRQ_LIM = 5;
`else
  localparam int IRQ_LIM = 3;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        up_rreq, up_rack, up_wreq, up_wack, irq;
  logic [31:0] up_raddr, up_waddr, up_wdata, up_rdata;
  logic [31:0] gpio_io_i, gpio_io_o, gpio_io_t;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] addr_q[$];

  // Reference model state
  logic [31:0] m_pins, m_out, m_tri;
  logic        m_gier, m_ier, m_isr;

  up_gpio_core #(
    .ADDRESS_WIDTH (32),
    .BUS_WIDTH     (4),
    .GPIO_WIDTH    (32),
    .IRQ_ENABLE    (1)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .up_rreq   (up_rreq),
    .up_rack   (up_rack),
    .up_raddr  (up_raddr),
    .up_rdata  (up_rdata),
    .up_wreq   (up_wreq),
    .up_wack   (up_wack),
    .up_waddr  (up_waddr),
    .up_wdata  (up_wdata),
    .irq       (irq),
    .gpio_io_i (gpio_io_i),
    .gpio_io_o (gpio_io_o),
    .gpio_io_t (gpio_io_t)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [11:0] off;
    off = a[11:0] & 12'hFFC;
    case (off)
      12'h000: return (m_pins & m_tri) | (m_out & ~m_tri);
      12'h004: return m_tri;
      12'h11C: return {m_gier, 31'b0};
      12'h120: return {31'b0, m_isr};
      12'h128: return {31'b0, m_ier};
      default: return 32'h0;
    endcase
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d);
    logic [11:0] off;
    off = a[11:0] & 12'hFFC;
    case (off)
      12'h000: m_out  = d;
      12'h004: m_tri  = d;
      12'h11C: m_gier = d[31];
      12'h120: if (d[0]) m_isr = 1'b0;
      12'h128: m_ier  = d[0];
      default: ;
    endcase
  endfunction

  function automatic void model_reset();
    m_out = 32'h0; m_tri = 32'hFFFF_FFFF;
    m_gier = 1'b0; m_ier = 1'b0; m_isr = 1'b0;
  endfunction

  // Monitor: every ack must follow a request by exactly one cycle; read data popped from scoreboard.
  logic mon_rreq, mon_wreq, mon_rraw, mon_wraw;
  always @(posedge clk) begin
    mon_rraw = up_rreq;
    mon_wraw = up_wreq;
    mon_rreq = up_rreq & rstn;
    mon_wreq = up_wreq & rstn;
    #1;
    if (mon_rraw || up_rack) cmp("rack_timing", {31'b0, up_rack}, {31'b0, mon_rreq});
    if (mon_wraw || up_wack) cmp("wack_timing", {31'b0, up_wack}, {31'b0, mon_wreq});
    if (up_rack) begin
      if (exp_q.size() == 0) begin
        cmp("unexpected_rack", 32'h1, 32'h0);
      end else begin
        logic [31:0] e, a;
        e = exp_q.pop_front();
        a = addr_q.pop_front();
        cmp($sformatf("rdata@%h", a), up_rdata, e);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] e);
    exp_q.push_back(e);
    addr_q.push_back(a);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    up_wreq = 1'b1; up_waddr = a; up_wdata = d;
    model_write(a, d);
    @(negedge clk);
    up_wreq = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a);
    up_rreq = 1'b1; up_raddr = a;
    push_exp(a, model_read(a));
    @(negedge clk);
    up_rreq = 1'b0;
  endtask

  task automatic rd_exp(input logic [31:0] a, input logic [31:0] e);
    up_rreq = 1'b1; up_raddr = a;
    push_exp(a, e);
    @(negedge clk);
    up_rreq = 1'b0;
  endtask

  task automatic rd_held(input logic [31:0] a, input int n);
    up_rreq = 1'b1; up_raddr = a;
    repeat (n) begin
      push_exp(a, model_read(a));
      @(negedge clk);
    end
    up_rreq = 1'b0;
  endtask

  // Simultaneous read and write: the read observes the state before the write.
  task automatic rdwr(input logic [31:0] ra, input logic [31:0] wa, input logic [31:0] wd);
    up_rreq = 1'b1; up_raddr = ra;
    up_wreq = 1'b1; up_waddr = wa; up_wdata = wd;
    push_exp(ra, model_read(ra));
    model_write(wa, wd);
    @(negedge clk);
    up_rreq = 1'b0; up_wreq = 1'b0;
  endtask

  task automatic set_pins(input logic [31:0] v);
    if (((m_pins ^ v) & m_tri) != 32'h0) m_isr = 1'b1;
    m_pins = v;
    gpio_io_i = v;
    idle(6);
  endtask

  task automatic check_pins(input string tag);
    idle(3);
    cmp({tag, "_gpio_o"}, gpio_io_o, m_out);
    cmp({tag, "_gpio_t"}, gpio_io_t, m_tri);
    cmp({tag, "_irq"}, {31'b0, irq}, {31'b0, m_gier & m_ier & m_isr});
  endtask

  function automatic logic [31:0] rand_addr();
    logic [11:0] offs [10];
    offs = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h11C, 12'h120, 12'h128, 12'h200, 12'h124, 12'hFFC};
    return ($urandom & 32'hFFFF_F000) | {20'h0, offs[$urandom_range(0, 9)]} | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    int n;
    bit risen;
    rstn = 1'b0; up_rreq = 1'b0; up_wreq = 1'b0;
    up_raddr = '0; up_waddr = '0; up_wdata = '0; gpio_io_i = '0;
    m_pins = '0; model_reset();
    idle(3);
    cmp("reset_gpio_t", gpio_io_t, 32'hFFFF_FFFF);
    cmp("reset_gpio_o", gpio_io_o, 32'h0);
    cmp("reset_irq", {31'b0, irq}, 32'h0);
    cmp("reset_rdata", up_rdata, 32'h0);
    rstn = 1'b1;
    idle(1);

    rd_exp(32'h004, 32'hFFFF_FFFF);
    check_pins("post_reset");

    wr(32'h004, 32'hFFFF_FFFF);
    set_pins(32'h0000_01F4);
    rd_exp(32'h000, 32'h0000_01F4);

    wr(32'h004, 32'h0);
    wr(32'h000, 32'hBABE_DEAD);
    check_pins("drive_all");
    cmp("drive_all_o_lit", gpio_io_o, 32'hBABE_DEAD);
    rd_exp(32'h000, 32'hBABE_DEAD);

    wr(32'h004, 32'hFF00_00FF);
    wr(32'h000, 32'h1234_5678);
    set_pins(32'hAAAA_AAAA);
    rd_exp(32'h000, 32'hAA34_56AA);

    // Interrupt path
    wr(32'h004, 32'hFFFF_FFFF);
    set_pins(32'h0000_07D0);
    wr(32'h120, 32'h1);
    wr(32'h11C, 32'hFFFF_FFFF);
    wr(32'h128, 32'hFFFF_FFFF);
    check_pins("irq_armed");
    gpio_io_i = 32'h0000_07DA; m_pins = 32'h0000_07DA; m_isr = 1'b1;
    n = 0; risen = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (irq && !risen) begin risen = 1'b1; n = i; end
    end
    @(negedge clk);
    cmp($sformatf("irq_rise_within_%0d_cycles(n=%0d)", IRQ_LIM, n),
        {31'b0, (risen && n <= IRQ_LIM)}, 32'h1);
    wr(32'h120, 32'h1);
    check_pins("irq_cleared");
    rd_exp(32'h120, 32'h0);

    wr(32'h128, 32'h0);
    set_pins(32'h0000_1234);
    rd_exp(32'h120, 32'h1);
    check_pins("ier_off");
    cmp("ier_off_irq_lit", {31'b0, irq}, 32'h0);
    rd_exp(32'h008, 32'h0);
    rd_exp(32'h200, 32'h0);
    rd_exp(32'h11C, 32'h8000_0000);

    // Randomized traffic
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 8))
        0: wr(($urandom & 32'hFFFF_F000) | 32'h004, ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom);
        1: wr(32'h000 | 32'($urandom_range(0, 3)), $urandom);
        2: set_pins($urandom);
        3: rd(rand_addr());
        4: rdwr(rand_addr(), rand_addr(), $urandom);
        5: wr(($urandom_range(0, 1) != 0) ? 32'h11C : 32'h128, $urandom);
        6: wr(32'h120, 32'($urandom_range(0, 1)));
        7: rd_held(rand_addr(), $urandom_range(1, 4));
        default: wr(rand_addr(), $urandom);
      endcase
      if ($urandom_range(0, 7) == 0) check_pins("rand");
    end
    check_pins("rand_end");

    // Reset during traffic
    set_pins(32'h0);
    up_rreq = 1'b1; up_raddr = 32'h004;
    push_exp(32'h004, model_read(32'h004));
    @(posedge clk); #2;
    rstn = 1'b0;
    up_wreq = 1'b1; up_waddr = 32'h004; up_wdata = 32'h0;
    #1;
    cmp("async_reset_rack", {31'b0, up_rack}, 32'h0);
    cmp("async_reset_gpio_t", gpio_io_t, 32'hFFFF_FFFF);
    cmp("async_reset_irq", {31'b0, irq}, 32'h0);
    idle(3);
    up_rreq = 1'b0; up_wreq = 1'b0;
    rstn = 1'b1;
    model_reset();
    idle(1);
    rd_exp(32'h004, 32'hFFFF_FFFF);
    rd(32'h000);
    rd(32'h120);
    check_pins("after_reset");

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) cmp("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/up_gpio_core.md
Name: up_gpio_core

Overview:
- Single-channel GPIO peripheral on the codebase's simple uP register bus (req/ack read and write ports).
- Register map follows the AXI GPIO layout: data, tri-state, global interrupt enable, interrupt enable and interrupt status.
- Sits between a bus bridge (AXI-Lite/Wishbone to uP) and the pad/tri-state buffers.

Parameters:
- ADDRESS_WIDTH, 32, width of up_raddr/up_waddr (byte addresses).
- BUS_WIDTH, 4, data bus width in bytes; data width = BUS_WIDTH*8; word index = addr >> log2(BUS_WIDTH).
- GPIO_WIDTH, 32, number of GPIO pins (1..BUS_WIDTH*8).
- IRQ_ENABLE, 1, 1 = interrupt logic present; 0 = interrupt registers read 0 and irq tied 0.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rstn  in  1  asynchronous active-low reset.
- up_rreq  in  1  read request, one-cycle pulse or held.
- up_rack  out  1  read acknowledge.
- up_raddr  in  ADDRESS_WIDTH  read byte address.
- up_rdata  out  BUS_WIDTH*8  read data, valid while up_rack=1.
- up_wreq  in  1  write request.
- up_wack  out  1  write acknowledge.
- up_waddr  in  ADDRESS_WIDTH  write byte address.
- up_wdata  in  BUS_WIDTH*8  write data.
- irq  out  1  level interrupt, active high.
- gpio_io_i  in  GPIO_WIDTH  pin inputs.
- gpio_io_o  out  GPIO_WIDTH  pin output values.
- gpio_io_t  out  GPIO_WIDTH  tri-state control per pin; 1 = input (hi-Z), 0 = drive gpio_io_o.

Behaviour:
- Reset (async, rstn=0):
  - gpio_io_t = all 1 (all inputs); gpio_io_o = 0; irq = 0.
  - up_rack = 0, up_wack = 0, up_rdata = 0.
  - GIER, IER and ISR = 0; input sample register = 0.
- Address decode: byte offset bits [11:0]; upper bits ignored; sub-word bits ignored.
- Register map:
  - 0x000 GPIO_DATA.
  - 0x004 GPIO_TRI.
  - 0x008 GPIO2_DATA, reserved: reads 0, writes ignored.
  - 0x00C GPIO2_TRI, reserved: reads 0, writes ignored.
  - 0x11C GIER: bit31 = global interrupt enable.
  - 0x120 IP_ISR: bit0 = channel-1 status.
  - 0x128 IP_IER: bit0 = channel-1 enable.
  - Any other offset reads 0, writes ignored, and is still acknowledged.
- Handshake:
  - up_rack/up_wack = registered copy of up_rreq/up_wreq: asserted exactly 1 cycle after the request cycle, for 1 cycle per request cycle.
  - A request held N cycles yields N acks, one per request cycle.
  - Reads and writes may occur in the same cycle and are independent.
- Read data: registered and presented in the ack cycle.
  - GPIO_DATA: (gpio_in & gpio_io_t) | (gpio_io_o & ~gpio_io_t), zero-extended.
  - GPIO_TRI: gpio_io_t.
  - GIER: {enable,31'b0}.
  - IER and ISR: {31'b0,bit0}.
- gpio_in: gpio_io_i sampled by one register stage (2 stages extra with the optional feature).
- Writes take effect in the cycle after the request, with the same timing as the ack:
  - GPIO_DATA write: gpio_io_o = wdata[GPIO_WIDTH-1:0] for all bits, including bits currently inputs.
  - GPIO_TRI write: gpio_io_t = wdata[GPIO_WIDTH-1:0].
- Interrupt (IRQ_ENABLE=1):
  - Change event = any bit where gpio_in differs from its previous-cycle value AND gpio_io_t=1 for that bit.
  - Change event sets ISR bit0.
  - Writing 1 to ISR bit0 clears it; writing 0 has no effect.
  - Set and clear in the same cycle: set wins.
  - ISR bits 31:1, IER bits 31:1 and GIER bits 30:0 read 0.
  - irq registered: irq = GIER[31] & ISR[0] & IER[0], one cycle after the contributing state changes.
  - ISR sets regardless of IER/GIER.
- Reset mid-transaction: pending ack dropped; no ack after reset release for requests issued during reset.

Optional Feature:
- Macro UP_GPIO_INPUT_SYNC_EN.
- Defined: gpio_io_i passes through a 2-flop synchronizer (reset 0) before the sample register. GPIO_DATA read and change detect see pins 2 cycles later.
- Undefined: single sample register only.
- Register map and handshake are identical in both cases.

Decomposition:
- Shared package: register offset constants (GPIO_DATA, GPIO_TRI, GPIO2_DATA, GPIO2_TRI, GIER, IP_ISR, IP_IER) and GIER enable bit index.
- One sub-module, up_gpio_irq: change detector + ISR/IER/GIER registers + irq output. Generated only when IRQ_ENABLE=1.

Test Plan:
- After reset, read 0x004 -> rdata 0xFFFFFFFF, rack 1 cycle after rreq; gpio_io_o=0; irq=0.
- Write 0x004=0xFFFFFFFF, drive gpio_io_i=0x000001F4, read 0x000 -> 0x000001F4; wack 1 cycle after wreq.
- Write 0x004=0x00000000, write 0x000=0xBABEDEAD -> gpio_io_o=0xBABEDEAD, gpio_io_t=0; read 0x000 -> 0xBABEDEAD.
- Write 0x004=0xFF0000FF, 0x000=0x12345678, gpio_io_i=0xAAAAAAAA -> read 0x000 = 0xAA3456AA.
- Write 0x11C=0xFFFFFFFF, 0x128=0xFFFFFFFF, all inputs, change gpio_io_i 0x7D0->0x7DA:
  - irq rises within 3 cycles (5 with sync).
  - Write 0x120=0x1 -> irq falls, ISR reads 0.
- IER=0 with input change -> ISR reads 1, irq stays 0. Read 0x008 and 0x200 -> 0 with rack asserted.
